tx_meta_arbiter: RTL and testbench

TX_META_ARBITER -- requirements
Module: tx_meta_arbiter

---
 rtl/roce_arb_pkg.sv | 12 +
 rtl/tag_fifo.sv | 53 +++++
 rtl/tx_meta_arbiter.sv | 115 +++++++++++
 tb/tb_tx_meta_arbiter.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/roce_arb_pkg.sv
// roce_arb_pkg: shared FSM state, default parameters and tag-width helper for the tx_meta arbiter
package roce_arb_pkg;
  typedef enum logic {ARB, SEND} state_e;
  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_META_W = 256;
  localparam int DEF_STATUS_W = 512;
  localparam int DEF_MAX_OUTSTANDING = 8;
  localparam int DEF_TAG_DEPTH = 32;
  function automatic int tag_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/tag_fifo.sv
// tag_fifo: in-order owner-tag FIFO with registered occupancy, full and empty
module tag_fifo
  import roce_arb_pkg::*;
#(
  parameter int DEPTH = DEF_TAG_DEPTH,
  parameter int W = 2
) (
  input  logic                         ap_clk,
  input  logic                         ap_rst_n,
  input  logic                         push,
  input  logic [W-1:0]                 push_data,
  input  logic                         pop,
  output logic [W-1:0]                 head,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int PW = tag_w(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic push_ok, pop_ok;
  assign full = count_q == CW'(DEPTH);
  assign empty = count_q == '0;
  assign count = count_q;
  assign head = mem_q[rd_ptr_q];
  assign push_ok = push && !full;
  assign pop_ok = pop && !empty;
  // next storage, pointer and occupancy values; pointers wrap naturally at a power-of-2 depth
  always_comb begin
    mem_d = mem_q;
    if (push_ok) mem_d[wr_ptr_q] = push_data;
    wr_ptr_d = push_ok ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop_ok ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d = count_q + CW'(push_ok) - CW'(pop_ok);
  end
  // storage needs no reset: occupancy alone says which entries are live
  always_ff @(posedge ap_clk) mem_q <= mem_d;
  // pointers and occupancy, cleared by reset to empty the FIFO
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
    end
  end
endmodule

// File: rtl/tx_meta_arbiter.sv
// tx_meta_arbiter: round-robin arbiter of requester commands onto the RoCE tx_meta stream with in-order completion routing
module tx_meta_arbiter
  import roce_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int META_W = DEF_META_W,
  parameter int STATUS_W = DEF_STATUS_W,
  parameter int MAX_OUTSTANDING = DEF_MAX_OUTSTANDING,
  parameter int TAG_DEPTH = DEF_TAG_DEPTH
) (
  input  logic                             ap_clk,
  input  logic                             ap_rst_n,
  input  logic                             enable,
  input  logic [NUM_REQ-1:0]               s_axis_req_tvalid,
  output logic [NUM_REQ-1:0]               s_axis_req_tready,
  input  logic [NUM_REQ*META_W-1:0]        s_axis_req_tdata,
  output logic                             m_axis_tx_meta_tvalid,
  input  logic                             m_axis_tx_meta_tready,
  output logic [META_W-1:0]                m_axis_tx_meta_tdata,
  output logic [META_W/8-1:0]              m_axis_tx_meta_tkeep,
  output logic                             m_axis_tx_meta_tlast,
  input  logic                             s_axis_tx_status_tvalid,
  output logic                             s_axis_tx_status_tready,
  input  logic [STATUS_W-1:0]              s_axis_tx_status_tdata,
  output logic [NUM_REQ-1:0]               cmpl_valid,
  output logic [STATUS_W-1:0]              cmpl_status,
  output logic [$clog2(TAG_DEPTH+1)-1:0]   outstanding_total
);
  localparam int IW = tag_w(NUM_REQ);
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  state_e state_q, state_d;
  logic [IW-1:0] last_grant_q, last_grant_d;
  logic [META_W-1:0] tdata_q, tdata_d;
  logic [NUM_REQ-1:0] cmpl_valid_q, cmpl_valid_d;
  logic [STATUS_W-1:0] cmpl_status_q, cmpl_status_d;
  logic [OW-1:0] out_q [NUM_REQ];
  logic [OW-1:0] out_d [NUM_REQ];
  logic [NUM_REQ-1:0] elig;
  logic grant_found, take, push, pop, fifo_full, fifo_empty;
  logic [IW-1:0] grant_idx, fifo_head;
  int idx;
  assign take = state_q == ARB && grant_found;
  assign push = state_q == SEND && m_axis_tx_meta_tready;
  assign pop = s_axis_tx_status_tvalid && !fifo_empty;
  assign m_axis_tx_meta_tdata = tdata_q;
  assign m_axis_tx_meta_tkeep = '1;
  assign m_axis_tx_meta_tlast = 1'b1;
  assign s_axis_tx_status_tready = !fifo_empty;
  assign cmpl_valid = cmpl_valid_q;
  assign cmpl_status = cmpl_status_q;
  // eligibility and first-eligible search starting just after the last grant
  always_comb begin
    elig = '0;
    grant_found = 1'b0;
    grant_idx = '0;
    idx = 0;
    for (int i = 0; i < NUM_REQ; i++)
      elig[i] = enable && s_axis_req_tvalid[i] && out_q[i] < OW'(MAX_OUTSTANDING) && !fifo_full;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(last_grant_q) + k) % NUM_REQ;
      if (!grant_found && elig[IW'(idx)]) begin
        grant_found = 1'b1;
        grant_idx = IW'(idx);
      end
    end
  end
  // FSM state register
  always_ff @(posedge ap_clk) state_q <= !ap_rst_n ? ARB : state_d;
  // FSM next state: ARB leaves on a grant, SEND leaves on the meta handshake
  always_comb state_d = (state_q == ARB) ? (grant_found ? SEND : ARB) : (m_axis_tx_meta_tready ? ARB : SEND);
  // FSM outputs: combinational accept for the winner, tvalid for the whole SEND state
  always_comb begin
    s_axis_req_tready = take ? NUM_REQ'(1) << grant_idx : '0;
    m_axis_tx_meta_tvalid = state_q == SEND;
  end
  // datapath next values; last_grant doubles as the owner of the in-flight command
  always_comb begin
    last_grant_d = take ? grant_idx : last_grant_q;
    tdata_d = take ? s_axis_req_tdata[int'(grant_idx)*META_W +: META_W] : tdata_q;
    cmpl_valid_d = pop ? NUM_REQ'(1) << fifo_head : '0;
    cmpl_status_d = pop ? s_axis_tx_status_tdata : cmpl_status_q;
    for (int i = 0; i < NUM_REQ; i++)
      out_d[i] = out_q[i] + OW'(push && last_grant_q == IW'(i)) - OW'(pop && fifo_head == IW'(i));
  end
  // datapath registers; reset discards the in-flight command and all counts
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      last_grant_q <= IW'(NUM_REQ - 1);
      tdata_q <= '0;
      cmpl_valid_q <= '0;
      cmpl_status_q <= '0;
      out_q <= '{default: '0};
    end else begin
      last_grant_q <= last_grant_d;
      tdata_q <= tdata_d;
      cmpl_valid_q <= cmpl_valid_d;
      cmpl_status_q <= cmpl_status_d;
      out_q <= out_d;
    end
  end
  tag_fifo #(
    .DEPTH(TAG_DEPTH),
    .W(IW)
  ) u_tag_fifo (
    .ap_clk(ap_clk),
    .ap_rst_n(ap_rst_n),
    .push(push),
    .push_data(last_grant_q),
    .pop(pop),
    .head(fifo_head),
    .full(fifo_full),
    .empty(fifo_empty),
    .count(outstanding_total)
  );
endmodule

// File: tb/tb_tx_meta_arbiter.sv
// tb_tx_meta_arbiter: scoreboard bench for the tx_meta arbiter
module tb_tx_meta_arbiter;
  localparam int NR = 4;
  localparam int MW = 256;
  localparam int SW = 512;
  localparam int MO = 8;
  localparam int TD = 32;
  typedef struct {
    int r;
    logic [SW-1:0] s;
  } cmpl_t;
  logic ap_clk = 1'b0;
  logic ap_rst_n = 1'b0;
  logic enable = 1'b1;
  logic [NR-1:0] req_valid = '0;
  logic [NR-1:0] req_tready;
  logic [NR*MW-1:0] req_tdata;
  logic [MW-1:0] req_data [NR];
  logic m_tvalid, m_tlast;
  logic m_tready = 1'b0;
  logic [MW-1:0] m_tdata;
  logic [MW/8-1:0] m_tkeep;
  logic st_valid = 1'b0;
  logic st_tready;
  logic [SW-1:0] st_data = '0;
  logic [NR-1:0] cmpl_valid;
  logic [SW-1:0] cmpl_status;
  logic [5:0] total;
  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int ev_grant;
  logic ev_meta, ev_stat;
  logic [MW-1:0] ev_meta_data;
  int pend_owner = 0;
  logic [MW-1:0] meta_q [$];
  int tag_q [$];
  cmpl_t cmpl_q [$];

  always #5 ap_clk = ~ap_clk;

  always_comb begin
    req_tdata = '0;
    for (int i = 0; i < NR; i++) req_tdata[i*MW +: MW] = req_data[i];
  end

  tx_meta_arbiter #(
    .NUM_REQ(NR), .META_W(MW), .STATUS_W(SW), .MAX_OUTSTANDING(MO), .TAG_DEPTH(TD)
  ) dut (
    .ap_clk(ap_clk),
    .ap_rst_n(ap_rst_n),
    .enable(enable),
    .s_axis_req_tvalid(req_valid),
    .s_axis_req_tready(req_tready),
    .s_axis_req_tdata(req_tdata),
    .m_axis_tx_meta_tvalid(m_tvalid),
    .m_axis_tx_meta_tready(m_tready),
    .m_axis_tx_meta_tdata(m_tdata),
    .m_axis_tx_meta_tkeep(m_tkeep),
    .m_axis_tx_meta_tlast(m_tlast),
    .s_axis_tx_status_tvalid(st_valid),
    .s_axis_tx_status_tready(st_tready),
    .s_axis_tx_status_tdata(st_data),
    .cmpl_valid(cmpl_valid),
    .cmpl_status(cmpl_status),
    .outstanding_total(total)
  );

  // samples the handshakes due at the next edge, records expectations, then advances one clock
  task automatic step();
    cmpl_t c;
    #1;
    ev_grant = -1;
    for (int i = 0; i < NR; i++) if (req_tready[i] === 1'b1) ev_grant = i;
    ev_meta = (m_tvalid === 1'b1) && (m_tready === 1'b1);
    ev_meta_data = m_tdata;
    ev_stat = (st_tready === 1'b1) && st_valid;
    if (ev_grant >= 0) begin
      meta_q.push_back(req_data[ev_grant]);
      pend_owner = ev_grant;
    end
    if (ev_meta) tag_q.push_back(pend_owner);
    if (ev_stat) begin
      c.r = (tag_q.size() > 0) ? tag_q.pop_front() : -1;
      c.s = st_data;
      cmpl_q.push_back(c);
    end
    @(posedge ap_clk);
    cyc++;
    #2;
    if (ev_grant >= 0) req_data[ev_grant] = {8{$urandom()}};
  endtask

  task automatic do_reset();
    ap_rst_n = 1'b0;
    req_valid = '0;
    m_tready = 1'b0;
    st_valid = 1'b0;
    enable = 1'b1;
    step();
    step();
    ap_rst_n = 1'b1;
    meta_q.delete();
    tag_q.delete();
    cmpl_q.delete();
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (m_tvalid !== 1'b0) begin n_fail++; $display("FAIL reset_tvalid: got %b exp 0", m_tvalid); end
    n_checks++; if (m_tdata !== '0) begin n_fail++; $display("FAIL reset_tdata: got %h exp 0", m_tdata); end
    n_checks++; if (cmpl_valid !== '0) begin n_fail++; $display("FAIL reset_cmpl_valid: got %b exp 0", cmpl_valid); end
    n_checks++; if (cmpl_status !== '0) begin n_fail++; $display("FAIL reset_cmpl_status: got %h exp 0", cmpl_status); end
    n_checks++; if (total !== 6'd0) begin n_fail++; $display("FAIL reset_total: got %0d exp 0", total); end
    n_checks++; if (st_tready !== 1'b0) begin n_fail++; $display("FAIL reset_st_tready: got %b exp 0", st_tready); end
    n_checks++; if (m_tkeep !== {(MW/8){1'b1}}) begin n_fail++; $display("FAIL reset_tkeep: got %h exp all ones", m_tkeep); end
    n_checks++; if (m_tlast !== 1'b1) begin n_fail++; $display("FAIL reset_tlast: got %b exp 1", m_tlast); end
    n_checks++; if (req_tready !== 4'b0000) begin n_fail++; $display("FAIL reset_req_tready: got %b exp 0000", req_tready); end
    req_valid = '1;
    #1;
    n_checks++; if (req_tready !== 4'b0001) begin n_fail++; $display("FAIL reset_first_winner: got %b exp 0001", req_tready); end
    req_valid = '0;
  endtask

  task automatic test_round_robin();
    int exp_g [$];
    int n_g, last_c, e, n_c;
    logic [MW-1:0] em;
    cmpl_t c;
    do_reset();
    for (int i = 0; i < NR * MO; i++) exp_g.push_back(i % NR);
    n_g = 0;
    last_c = 0;
    m_tready = 1'b1;
    req_valid = '1;
    for (int t = 0; t < 80; t++) begin
      step();
      if (ev_grant >= 0) begin
        e = (exp_g.size() > 0) ? exp_g.pop_front() : -1;
        n_checks++; if (ev_grant != e) begin n_fail++; $display("FAIL rr_grant: got %0d exp %0d", ev_grant, e); end
        if (n_g > 0) begin
          n_checks++; if (cyc - last_c != 2) begin n_fail++; $display("FAIL rr_gap: got %0d exp 2", cyc - last_c); end
        end
        n_g++;
        last_c = cyc;
      end
      if (ev_meta) begin
        em = (meta_q.size() > 0) ? meta_q.pop_front() : 'x;
        n_checks++; if (ev_meta_data !== em) begin n_fail++; $display("FAIL rr_meta: got %h exp %h", ev_meta_data, em); end
      end
    end
    n_checks++; if (n_g != NR * MO) begin n_fail++; $display("FAIL rr_count: got %0d exp %0d", n_g, NR * MO); end
    n_checks++; if (total !== 6'd32) begin n_fail++; $display("FAIL rr_total_full: got %0d exp 32", total); end
    req_valid = '0;
    st_valid = 1'b1;
    n_c = 0;
    for (int t = 0; t < 40; t++) begin
      st_data = {16{$urandom()}};
      step();
      if (ev_stat) begin
        c = cmpl_q.pop_front();
        n_c++;
        n_checks++; if (cmpl_valid !== NR'(1 << c.r) || cmpl_status !== c.s) begin n_fail++; $display("FAIL rr_cmpl: got %b/%h exp %b/%h", cmpl_valid, cmpl_status, NR'(1 << c.r), c.s); end
      end else begin
        n_checks++; if (cmpl_valid !== '0) begin n_fail++; $display("FAIL rr_cmpl_idle: got %b exp 0000", cmpl_valid); end
      end
    end
    st_valid = 1'b0;
    n_checks++; if (n_c != NR * MO) begin n_fail++; $display("FAIL rr_drain_count: got %0d exp %0d", n_c, NR * MO); end
    n_checks++; if (total !== 6'd0) begin n_fail++; $display("FAIL rr_total_empty: got %0d exp 0", total); end
    n_checks++; if (st_tready !== 1'b0) begin n_fail++; $display("FAIL rr_st_tready_empty: got %b exp 0", st_tready); end
  endtask

  task automatic test_max_outstanding();
    int n_g;
    logic [SW-1:0] es;
    logic [MW-1:0] em;
    do_reset();
    m_tready = 1'b1;
    req_valid = 4'b0100;
    n_g = 0;
    for (int t = 0; t < 30; t++) begin
      step();
      if (ev_grant >= 0) begin
        n_g++;
        n_checks++; if (ev_grant != 2) begin n_fail++; $display("FAIL max_grant_id: got %0d exp 2", ev_grant); end
      end
      if (ev_meta) begin
        em = (meta_q.size() > 0) ? meta_q.pop_front() : 'x;
        n_checks++; if (ev_meta_data !== em) begin n_fail++; $display("FAIL max_meta: got %h exp %h", ev_meta_data, em); end
      end
    end
    n_checks++; if (n_g != MO) begin n_fail++; $display("FAIL max_issued: got %0d exp %0d", n_g, MO); end
    n_checks++; if (req_tready !== 4'b0000) begin n_fail++; $display("FAIL max_blocked: got %b exp 0000", req_tready); end
    n_checks++; if (total !== 6'd8) begin n_fail++; $display("FAIL max_total: got %0d exp 8", total); end
    st_valid = 1'b1;
    st_data = {16{$urandom()}};
    es = st_data;
    step();
    st_valid = 1'b0;
    n_checks++; if (cmpl_valid !== 4'b0100) begin n_fail++; $display("FAIL max_cmpl_valid: got %b exp 0100", cmpl_valid); end
    n_checks++; if (cmpl_status !== es) begin n_fail++; $display("FAIL max_cmpl_status: got %h exp %h", cmpl_status, es); end
    n_g = 0;
    for (int t = 0; t < 10; t++) begin
      step();
      if (ev_grant >= 0) n_g++;
    end
    n_checks++; if (n_g != 1) begin n_fail++; $display("FAIL max_ninth: got %0d exp 1", n_g); end
    n_checks++; if (total !== 6'd8) begin n_fail++; $display("FAIL max_total_after: got %0d exp 8", total); end
    req_valid = '0;
  endtask

  task automatic test_backpressure();
    logic [MW-1:0] em;
    do_reset();
    m_tready = 1'b0;
    req_valid = 4'b0011;
    step();
    n_checks++; if (ev_grant != 0) begin n_fail++; $display("FAIL bp_first_grant: got %0d exp 0", ev_grant); end
    em = (meta_q.size() > 0) ? meta_q.pop_front() : 'x;
    for (int k = 0; k < 10; k++) begin
      if (k == 4) enable = 1'b0;
      step();
      n_checks++; if (m_tvalid !== 1'b1 || m_tdata !== em) begin n_fail++; $display("FAIL bp_hold: got %b/%h exp 1/%h", m_tvalid, m_tdata, em); end
      n_checks++; if (ev_grant != -1 || ev_meta) begin n_fail++; $display("FAIL bp_no_grant: got grant %0d meta %b exp -1/0", ev_grant, ev_meta); end
    end
    m_tready = 1'b1;
    step();
    n_checks++; if (!ev_meta || ev_meta_data !== em) begin n_fail++; $display("FAIL bp_handshake: got %b/%h exp 1/%h", ev_meta, ev_meta_data, em); end
    n_checks++; if (m_tvalid !== 1'b0) begin n_fail++; $display("FAIL bp_tvalid_drop: got %b exp 0", m_tvalid); end
    for (int k = 0; k < 3; k++) begin
      step();
      n_checks++; if (ev_grant != -1 || m_tvalid !== 1'b0) begin n_fail++; $display("FAIL bp_disabled: got grant %0d tvalid %b exp -1/0", ev_grant, m_tvalid); end
    end
    enable = 1'b1;
    #1;
    n_checks++; if (req_tready !== 4'b0010) begin n_fail++; $display("FAIL bp_next_rr: got %b exp 0010", req_tready); end
    req_valid = '0;
    m_tready = 1'b0;
  endtask

  task automatic test_cmpl_order();
    do_reset();
    m_tready = 1'b1;
    req_valid = 4'b0010;
    step();
    n_checks++; if (ev_grant != 1) begin n_fail++; $display("FAIL ord_grant1: got %0d exp 1", ev_grant); end
    req_valid = 4'b1000;
    step();
    step();
    n_checks++; if (ev_grant != 3) begin n_fail++; $display("FAIL ord_grant3: got %0d exp 3", ev_grant); end
    req_valid = '0;
    step();
    n_checks++; if (total !== 6'd2) begin n_fail++; $display("FAIL ord_total: got %0d exp 2", total); end
    st_valid = 1'b1;
    st_data = 512'hA;
    step();
    n_checks++; if (cmpl_valid !== 4'b0010 || cmpl_status !== 512'hA) begin n_fail++; $display("FAIL ord_first: got %b/%h exp 0010/a", cmpl_valid, cmpl_status); end
    st_data = 512'hB;
    step();
    n_checks++; if (cmpl_valid !== 4'b1000 || cmpl_status !== 512'hB) begin n_fail++; $display("FAIL ord_second: got %b/%h exp 1000/b", cmpl_valid, cmpl_status); end
    st_valid = 1'b0;
    step();
    n_checks++; if (cmpl_valid !== 4'b0000 || total !== 6'd0) begin n_fail++; $display("FAIL ord_idle: got %b/%0d exp 0000/0", cmpl_valid, total); end
  endtask

  task automatic test_simultaneous();
    int n_g;
    logic [SW-1:0] es;
    do_reset();
    m_tready = 1'b1;
    req_valid = 4'b0001;
    step();
    step();
    step();
    n_checks++; if (m_tvalid !== 1'b1 || total !== 6'd1) begin n_fail++; $display("FAIL sim_setup: got tvalid %b total %0d exp 1/1", m_tvalid, total); end
    st_valid = 1'b1;
    st_data = {16{$urandom()}};
    es = st_data;
    req_valid = '0;
    step();
    st_valid = 1'b0;
    n_checks++; if (!(ev_meta && ev_stat)) begin n_fail++; $display("FAIL sim_both: got meta %b stat %b exp 1/1", ev_meta, ev_stat); end
    n_checks++; if (total !== 6'd1) begin n_fail++; $display("FAIL sim_total: got %0d exp 1", total); end
    n_checks++; if (cmpl_valid !== 4'b0001 || cmpl_status !== es) begin n_fail++; $display("FAIL sim_cmpl: got %b/%h exp 0001/%h", cmpl_valid, cmpl_status, es); end
    req_valid = 4'b0001;
    n_g = 0;
    for (int t = 0; t < 30; t++) begin
      step();
      if (ev_grant >= 0) n_g++;
    end
    n_checks++; if (n_g != MO - 1) begin n_fail++; $display("FAIL sim_outstanding: got %0d more grants exp %0d", n_g, MO - 1); end
    n_checks++; if (total !== 6'd8) begin n_fail++; $display("FAIL sim_total_final: got %0d exp 8", total); end
    req_valid = '0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    m_tready = 1'b1;
    req_valid = '1;
    for (int t = 0; t < 40 && tag_q.size() < 5; t++) step();
    n_checks++; if (total !== 6'd5) begin n_fail++; $display("FAIL rst_pre_total: got %0d exp 5", total); end
    ap_rst_n = 1'b0;
    step();
    ap_rst_n = 1'b1;
    meta_q.delete();
    tag_q.delete();
    cmpl_q.delete();
    n_checks++; if (total !== 6'd0 || st_tready !== 1'b0 || m_tvalid !== 1'b0) begin n_fail++; $display("FAIL rst_cleared: got total %0d st_tready %b tvalid %b exp 0/0/0", total, st_tready, m_tvalid); end
    n_checks++; if (req_tready !== 4'b0001) begin n_fail++; $display("FAIL rst_next_grant: got %b exp 0001", req_tready); end
    st_valid = 1'b1;
    st_data = {16{$urandom()}};
    step();
    st_valid = 1'b0;
    n_checks++; if (ev_stat || cmpl_valid !== 4'b0000) begin n_fail++; $display("FAIL rst_status_refused: got stat %b cmpl %b exp 0/0000", ev_stat, cmpl_valid); end
    n_checks++; if (ev_grant != 0) begin n_fail++; $display("FAIL rst_grant0: got %0d exp 0", ev_grant); end
    req_valid = '0;
    m_tready = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < NR; i++) req_data[i] = {8{$urandom()}};
    test_reset();
    test_round_robin();
    test_max_outstanding();
    test_backpressure();
    test_cmpl_order();
    test_simultaneous();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
